// File: rtl/qick_pack_pkg.sv
// Shared types for the bit-to-byte packer.
// FIFO word layout and bit placement helper.
package qick_pack_pkg;

    localparam int BYTE_W  = 8;
    localparam int NBITS_W = 4;

    typedef struct packed {
        logic [BYTE_W-1:0]  dout;
        logic [NBITS_W-1:0] nbits;
        logic               last;
    } pack_word_t;

    // 7-cnt equals ~cnt for a 3-bit count
    function automatic logic [2:0] bit_pos(
        input logic       msb_first,
        input logic [2:0] cnt
    );
        return msb_first ? ~cnt : cnt;
    endfunction

endpackage

// File: rtl/pack_fifo.sv
// Small synchronous FIFO of packed byte words.
// Flags are registered from next occupancy.
module pack_fifo
    import qick_pack_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  pack_word_t push_data,
    input  logic       pop,
    output pack_word_t pop_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    pack_word_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_nxt = count;
        unique case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/bits_to_byte_packer.sv
// Serial bit to byte packer with frame flush.
// Output bytes are buffered in pack_fifo.
module bits_to_byte_packer
    import qick_pack_pkg::*;
#(
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit PAD_VALUE  = 1'b0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              din_valid,
    input  logic              din_last,
    output logic              din_ready,
    output logic [BYTE_W-1:0] dout,
    output logic [NBITS_W-1:0] dout_nbits,
    output logic              dout_last,
    output logic              dout_valid,
    input  logic              dout_ready
);

    localparam logic [BYTE_W-1:0] PAD_FILL = {BYTE_W{PAD_VALUE}};

    logic [BYTE_W-1:0] sr;
    logic [BYTE_W-1:0] sr_ins;
    logic [2:0]        cnt;
    logic              rdy_q;
    logic              accept;
    logic              complete;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    pack_word_t        push_w;
    pack_word_t        pop_w;

    // rdy_q holds ready low until the first edge after reset release
    assign din_ready = rdy_q && !fifo_full;
    assign accept    = din_valid && din_ready;
    assign complete  = accept && ((cnt == 3'd7) || din_last);

    always_comb begin
        sr_ins = sr;
        sr_ins[bit_pos(MSB_FIRST, cnt)] = din;
    end

    always_comb begin
        push_w       = '0;
        push_w.dout  = sr_ins;
        push_w.nbits = {1'b0, cnt} + 4'd1;
        push_w.last  = din_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr    <= PAD_FILL;
            cnt   <= '0;
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (complete) begin
                sr  <= PAD_FILL;
                cnt <= '0;
            end else if (accept) begin
                sr  <= sr_ins;
                cnt <= cnt + 3'd1;
            end
        end
    end

    assign pop = dout_valid && dout_ready;

    pack_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (complete),
        .push_data(push_w),
        .pop      (pop),
        .pop_data (pop_w),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign dout_valid = !fifo_empty;
    assign dout       = pop_w.dout;
    assign dout_nbits = pop_w.nbits;
    assign dout_last  = pop_w.last;

endmodule

// File: tb/tb_bits_to_byte_packer.sv
// Scoreboard bench for bits_to_byte_packer.
// Three parameter variants share one stimulus stream.
module tb_bits_to_byte_packer;
    import qick_pack_pkg::*;

    localparam int NI = 3;
    localparam logic [NI-1:0] MSBV = 3'b101;
    localparam logic [NI-1:0] PADV = 3'b100;

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic din_valid;
    logic din_last;
    logic dout_ready;

    logic       rq [NI];
    logic [7:0] dq [NI];
    logic [3:0] nq [NI];
    logic       lq [NI];
    logic       vq [NI];

    int checks = 0;
    int failures = 0;

    bit         fb    [NI][$];
    pack_word_t exp_q [NI][$];
    pack_word_t lastp [NI];
    pack_word_t prev  [NI];
    bit         hold  [NI];
    bit         app   [NI];
    int         pops  [NI];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g
        bits_to_byte_packer #(
            .MSB_FIRST (MSBV[gi]),
            .PAD_VALUE (PADV[gi]),
            .FIFO_DEPTH(2)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .din       (din),
            .din_valid (din_valid),
            .din_last  (din_last),
            .din_ready (rq[gi]),
            .dout      (dq[gi]),
            .dout_nbits(nq[gi]),
            .dout_last (lq[gi]),
            .dout_valid(vq[gi]),
            .dout_ready(dout_ready)
        );
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // reference model: collect accepted bits, emit bytes by frame rules
    always @(negedge clk) begin
        pack_word_t w;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                fb[i].delete();
                exp_q[i].delete();
                app[i] = 1'b0;
            end else begin
                if (app[i]) begin
                    chk("latency_valid", 32'(vq[i]), 1);
                    app[i] = 1'b0;
                end
                if (din_valid && rq[i]) begin
                    fb[i].push_back(din);
                    if (fb[i].size() == 8 || din_last) begin
                        w.dout = {8{PADV[i]}};
                        for (int k = 0; k < fb[i].size(); k++)
                            w.dout[MSBV[i] ? 7 - k : k] = fb[i][k];
                        w.nbits = 4'(fb[i].size());
                        w.last = din_last;
                        exp_q[i].push_back(w);
                        fb[i].delete();
                        app[i] = 1'b1;
                    end
                end
            end
        end
    end

    // monitor: pop on handshake, check hold stability
    always @(negedge clk) begin
        pack_word_t cur;
        pack_word_t e;
        for (int i = 0; i < NI; i++) begin
            cur = '{dout: dq[i], nbits: nq[i], last: lq[i]};
            if (rst) begin
                hold[i] = 1'b0;
            end else begin
                if (hold[i]) begin
                    chk("hold_valid", 32'(vq[i]), 1);
                    chk("hold_stable", 32'(cur), 32'(prev[i]));
                end
                if (vq[i] && dout_ready) begin
                    if (exp_q[i].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte inst%0d: got %0h want none",
                                 i, cur);
                    end else begin
                        e = exp_q[i].pop_front();
                        chk("byte", 32'(cur), 32'(e));
                    end
                    lastp[i] = cur;
                    pops[i]++;
                end
                hold[i] = vq[i] && !dout_ready;
                prev[i] = cur;
            end
        end
    end

    task automatic send_bit(input logic b, input logic l);
        int n = 0;
        bit done = 1'b0;
        din = b;
        din_last = l;
        din_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (rq[0]) begin
                done = 1'b1;
            end else if (++n > 500) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: got ready=0 want ready=1");
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input int n, input bit l);
        for (int k = 0; k < n; k++)
            send_bit(v[7-k], l && (k == n - 1));
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) begin
            din = 1'($urandom_range(1));
            din_last = 1'($urandom_range(1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_last(input string nm, input pack_word_t e0,
                              input pack_word_t e1, input pack_word_t e2);
        chk({nm, "_i0"}, 32'(lastp[0]), 32'(e0));
        chk({nm, "_i1"}, 32'(lastp[1]), 32'(e1));
        chk({nm, "_i2"}, 32'(lastp[2]), 32'(e2));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int acc;
        int cyc_n;
        int n;
        rst = 1'b1;
        din = 1'b0;
        din_valid = 1'b0;
        din_last = 1'b0;
        dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_valid", 32'(vq[i]), 0);
            chk("rst_dout", 32'(dq[i]), 0);
            chk("rst_nbits", 32'(nq[i]), 0);
            chk("rst_last", 32'(lq[i]), 0);
            chk("rst_ready", 32'(rq[i]), 0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(rq[0]), 1);

        send_byte(8'hB2, 8, 1'b0);
        idle(3);
        check_last("full_byte", '{8'hB2, 4'd8, 1'b0},
                   '{8'h4D, 4'd8, 1'b0}, '{8'hB2, 4'd8, 1'b0});

        send_byte(8'hA0, 3, 1'b1);
        idle(3);
        check_last("partial", '{8'hA0, 4'd3, 1'b1},
                   '{8'h05, 4'd3, 1'b1}, '{8'hBF, 4'd3, 1'b1});

        p0 = pops[0];
        send_byte(8'h5A, 8, 1'b1);
        idle(3);
        chk("last_at_7_count", 32'(pops[0] - p0), 1);
        chk("last_at_7_word", 32'(lastp[0]), 32'({8'h5A, 4'd8, 1'b1}));

        p0 = pops[0];
        dout_ready = 1'b0;
        send_byte(8'h3C, 8, 1'b0);
        send_byte(8'hA5, 8, 1'b0);
        din = 1'b1;
        din_last = 1'b0;
        din_valid = 1'b1;
        @(negedge clk);
        chk("bp_ready_drop", 32'(rq[0]), 0);
        repeat (3) @(negedge clk);
        chk("bp_stall", 32'(rq[0]), 0);
        @(posedge clk);
        #1;
        dout_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_still_low", 32'(rq[0]), 0);
        @(negedge clk);
        chk("bp_ready_back", 32'(rq[0]), 1);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        send_byte(8'h86, 7, 1'b0);
        idle(4);
        chk("bp_pop_count", 32'(pops[0] - p0), 3);
        chk("bp_third", 32'(lastp[0]), 32'({8'hC3, 4'd8, 1'b0}));

        acc = 0;
        cyc_n = 0;
        while (acc < 10000 && cyc_n < 60000) begin
            din_valid = ($urandom_range(3) != 0);
            din = 1'($urandom_range(1));
            din_last = ($urandom_range(11) == 0);
            dout_ready = ($urandom_range(4) < 3);
            @(negedge clk);
            if (din_valid && rq[0])
                acc++;
            @(posedge clk);
            #1;
            cyc_n++;
        end
        chk("random_accepts", 32'(acc), 10000);
        dout_ready = 1'b1;
        send_bit(1'b0, 1'b1);
        n = 0;
        din_valid = 1'b0;
        while ((vq[0] || vq[1] || vq[2]) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < NI; i++) begin
            chk("drain_queue", 32'(exp_q[i].size()), 0);
            chk("drain_valid", 32'(vq[i]), 0);
        end

        dout_ready = 1'b0;
        send_byte(8'hFF, 8, 1'b0);
        send_byte(8'h80, 5, 1'b0);
        chk("pre_rst_valid", 32'(vq[0]), 1);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("async_rst_valid", 32'(vq[i]), 0);
            chk("async_rst_ready", 32'(rq[i]), 0);
            chk("async_rst_dout", 32'(dq[i]), 0);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        send_byte(8'hF0, 8, 1'b0);
        idle(3);
        check_last("post_rst", '{8'hF0, 4'd8, 1'b0},
                   '{8'h0F, 4'd8, 1'b0}, '{8'hF0, 4'd8, 1'b0});
        for (int i = 0; i < NI; i++)
            chk("final_queue", 32'(exp_q[i].size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
